// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit and its prediction queue.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_resolve_unit_pkg;
    localparam int ADDR_WIDTH  = `ADDR_WIDTH;
    localparam int INSTR_BYTES = 4;
    localparam int BRQ_DEPTH   = 8;
    localparam int BRQ_PTR_W   = $clog2(BRQ_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
        logic                  taken;
    } brq_entry_t;
endpackage

// File: rtl/branch_fb_ifc.sv
// Execute-stage branch feedback consumed by the next-PC predictor.
interface branch_fb_ifc;
    logic                                          if_branch;
    logic                                          if_prediction_correct;
    logic [branch_resolve_unit_pkg::ADDR_WIDTH-1:0] new_pc;

    modport out (output if_branch, if_prediction_correct, new_pc);
    modport in  (input  if_branch, if_prediction_correct, new_pc);
endinterface

// File: rtl/branch_pred_queue.sv
// 2-push / 2-pop circular FIFO of predictions. Lane 0 is always the older slot.
module branch_pred_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [1:0]               push,
    input  brq_entry_t               push_data [2],
    input  logic [1:0]               pop,
    output brq_entry_t               head [2],
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    brq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  wr1_ptr;
    logic [CNT_W-1:0]  npush;
    logic [CNT_W-1:0]  npop;

    assign npush   = CNT_W'(push[0]) + CNT_W'(push[1]);
    assign npop    = CNT_W'(pop[0]) + CNT_W'(pop[1]);
    // A lone lane-1 push lands in the tail slot, not one past it.
    assign wr1_ptr = push[0] ? wr_ptr + PTR_W'(1) : wr_ptr;

    assign head[0] = mem[rd_ptr];
    assign head[1] = mem[rd_ptr + PTR_W'(1)];
    assign ready   = (count <= CNT_W'(DEPTH - 2));

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + npush[PTR_W-1:0];
            rd_ptr <= rd_ptr + npop[PTR_W-1:0];
            count  <= count + npush - npop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            if (push[0]) mem[wr_ptr]  <= push_data[0];
            if (push[1]) mem[wr1_ptr] <= push_data[1];
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves up to two branches per cycle against queued predictions and
// registers per-lane feedback; a mispredict discards all wrong-path entries.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH  = BRQ_DEPTH,
    parameter int ADDR_W = `ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ext_flush,
    input  logic [1:0]              pred_push,
    input  logic [ADDR_W-1:0]       pred_pc [2],
    input  logic [ADDR_W-1:0]       pred_target [2],
    input  logic [1:0]              pred_taken,
    output logic                    pred_ready,
    input  logic [1:0]              res_valid,
    input  logic [1:0]              res_taken,
    input  logic [ADDR_W-1:0]       res_target [2],
    branch_fb_ifc.out               o_branch [2],
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err
);
    brq_entry_t         head [2];
    brq_entry_t         push_data [2];
    logic [1:0]         push_ok;
    logic [1:0]         resolve;
    logic [1:0]         correct;
    logic [ADDR_W-1:0]  actual [2];
    logic               mispredict;
    logic               q_flush;
    logic               proto_err;

    logic [1:0]         br_q;
    logic [1:0]         ok_q;
    logic [ADDR_W-1:0]  pc_q [2];

    for (genvar g = 0; g < 2; g++) begin : g_lane
        assign push_data[g] = '{pc: pred_pc[g], target: pred_target[g], taken: pred_taken[g]};
        assign correct[g]   = (head[g].taken == res_taken[g]) &&
                              (!res_taken[g] || head[g].target == res_target[g]);
        assign actual[g]    = res_taken[g] ? res_target[g] : head[g].pc + ADDR_W'(INSTR_BYTES);

        always_ff @(posedge clk) begin
            if (!reset) begin
                br_q[g] <= 1'b0;
                ok_q[g] <= 1'b0;
                pc_q[g] <= '0;
            end else begin
                br_q[g] <= resolve[g];
                ok_q[g] <= !resolve[g] || correct[g];
                pc_q[g] <= resolve[g] ? actual[g] : '0;
            end
        end

        assign o_branch[g].if_branch             = br_q[g];
        assign o_branch[g].if_prediction_correct = ok_q[g];
        assign o_branch[g].new_pc                = pc_q[g];
    end

    // Lane 1 is only evaluated behind a correctly predicted lane 0.
    assign resolve[0] = !ext_flush && res_valid[0] && (count != '0);
    assign resolve[1] = resolve[0] && correct[0] && res_valid[1] && (count >= 2);

    assign mispredict = (resolve[0] && !correct[0]) || (resolve[1] && !correct[1]);
    assign q_flush    = ext_flush || mispredict;
    assign push_ok    = pred_push & {2{pred_ready}};

    assign proto_err = !ext_flush && (
                           (|pred_push && !pred_ready) ||
                           (res_valid[0] && count == '0) ||
                           (res_valid[0] && res_valid[1] && count == 1 && correct[0]) ||
                           (res_valid[1] && !res_valid[0]));

    always_ff @(posedge clk) begin
        if (!reset)         err <= 1'b0;
        else if (proto_err) err <= 1'b1;
    end

    branch_pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (q_flush),
        .push      (push_ok),
        .push_data (push_data),
        .pop       (resolve),
        .head      (head),
        .count     (count),
        .ready     (pred_ready)
    );
endmodule
